// File: rtl/systolic_pkg.sv
// Shared constants and psum types for the systolic array datapath.
package systolic_pkg;
   localparam int SYS_N  = 16;
   localparam int PSUM_W = 32;

   typedef logic [PSUM_W-1:0] psum_t;
   typedef psum_t [SYS_N-1:0] psum_row_t;
endpackage

// File: rtl/systolic_drain_if.sv
// Bottom-edge bus of the array: skewed psum inputs in, aligned row stream out.
interface systolic_drain_if
   import systolic_pkg::*;
#(
   parameter int N     = SYS_N,
   parameter int WIDTH = PSUM_W
);
   logic [N-1:0][WIDTH-1:0] sys_output;
   logic [N-1:0]            sys_valid_out;
   logic [N-1:0][WIDTH-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic                    overflow;
   logic [15:0]             rows_out;

   modport master (
      output sys_output, sys_valid_out, out_ready,
      input  out_data, out_valid, overflow, rows_out
   );

   modport slave (
      input  sys_output, sys_valid_out, out_ready,
      output out_data, out_valid, overflow, rows_out
   );
endinterface

// File: rtl/drain_col_fifo.sv
// One column's de-skew FIFO; the head is read straight from the storage array.
module drain_col_fifo
   import systolic_pkg::*;
#(
   parameter int WIDTH = PSUM_W,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             drop
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty  = (count == '0);
   assign full   = (count == FULL_CNT);
   assign do_pop = pop && !empty;
   // A full FIFO still takes the word when its head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/systolic_drain.sv
// Collects the diagonal wavefront from the array bottom edge and emits one aligned row per beat.
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int N     = SYS_N,
   parameter int WIDTH = PSUM_W,
   parameter int DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   systolic_drain_if.slave  bus
);
   logic [N-1:0][WIDTH-1:0] dout_v;
   logic [N-1:0]            empty_v;
   logic [N-1:0]            full_v;
   logic [N-1:0]            drop_v;
   logic                    row_valid;
   logic                    pop;
   logic                    overflow_q;
   logic [15:0]             rows_q;

   for (genvar j = 0; j < N; j++) begin : g_col
      drain_col_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (bus.sys_valid_out[j]),
         .din   (bus.sys_output[j]),
         .pop   (pop),
         .dout  (dout_v[j]),
         .empty (empty_v[j]),
         .full  (full_v[j]),
         .drop  (drop_v[j])
      );

      a_drop_only_when_full: assert property (@(posedge clk) disable iff (!rst)
         drop_v[j] |-> full_v[j]);
   end

   // Row readiness comes only from FIFO occupancy, never from the array inputs.
   assign row_valid     = &(~empty_v);
   assign pop           = row_valid && bus.out_ready;
   assign bus.out_valid = row_valid;
   assign bus.out_data  = dout_v;
   assign bus.overflow  = overflow_q;
   assign bus.rows_out  = rows_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow_q <= 1'b0;
         rows_q     <= '0;
      end else begin
         if (|drop_v) overflow_q <= 1'b1;
         if (pop)     rows_q     <= rows_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: vector table plus skewed-stream sequences.
module tb_systolic_drain;
   import systolic_pkg::*;

   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic rst;

   systolic_drain_if #(.N(SYS_N), .WIDTH(PSUM_W)) bus ();

   systolic_drain #(
      .N     (SYS_N),
      .WIDTH (PSUM_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks  = 0;
   int n_fail    = 0;
   int exp_total = 0;

   typedef struct {
      logic [15:0] vmask;
      int          base;
      logic        rdy;
      logic        exp_valid;
      int          exp_base;
      int          exp_rows;
   } vec_t;

   vec_t vecs [9];

   function automatic psum_row_t mkrow(input int base, input int r);
      psum_row_t row;
      for (int j = 0; j < SYS_N; j++) row[j] = psum_t'(base + r*16 + j);
      return row;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic chk_row(input string name, input psum_row_t act, input psum_row_t req);
      int bad;
      bad = 0;
      n_checks++;
      if (act !== req) begin
         n_fail++;
         for (int j = SYS_N-1; j >= 0; j--) if (act[j] !== req[j]) bad = j;
         $display("FAIL %s: col %0d got %0h, expected %0h", name, bad, act[bad], req[bad]);
      end
   endtask

   task automatic drive_idle();
      bus.sys_valid_out = '0;
      bus.sys_output    = '0;
      bus.out_ready     = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      drive_idle();
      @(negedge clk);
      chk({tag, " out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, " overflow"},  32'(bus.overflow), 0);
      chk({tag, " rows_out"},  32'(bus.rows_out), 0);
      rst = 1'b1;
      exp_total = 0;
   endtask

   // Row r reaches column j at stream cycle r+j with value base + r*16 + j.
   task automatic stream(input string tag, input int base, input int nrows, input int rdy_cycle,
                         input int ncycles, input int exp_first, input int ovf_cycle,
                         input int exp_deliv, input bit exp_ovf_end);
      int        next_row;
      int        first;
      int        r;
      logic      hs;
      logic      held_v;
      psum_row_t held;
      next_row = 0;
      first    = -1;
      for (int c = 0; c < ncycles; c++) begin
         for (int j = 0; j < SYS_N; j++) begin
            r = c - j;
            bus.sys_valid_out[j] = (r >= 0 && r < nrows);
            bus.sys_output[j]    = (r >= 0 && r < nrows) ? psum_t'(base + r*16 + j) : '0;
         end
         bus.out_ready = (c >= rdy_cycle);
         hs     = bus.out_valid && bus.out_ready;
         held_v = bus.out_valid && !bus.out_ready;
         held   = bus.out_data;
         if (hs) begin
            chk_row({tag, " row"}, bus.out_data, mkrow(base, next_row));
            next_row++;
            exp_total++;
         end
         @(negedge clk);
         if (first < 0 && bus.out_valid) first = c;
         if (held_v) begin
            chk({tag, " stall valid"}, 32'(bus.out_valid), 1);
            chk_row({tag, " stall hold"}, bus.out_data, held);
         end
         if (ovf_cycle >= 0 && (c == ovf_cycle - 1 || c == ovf_cycle))
            chk({tag, " overflow rise"}, 32'(bus.overflow), 32'(c == ovf_cycle));
      end
      drive_idle();
      if (exp_first >= 0) chk({tag, " first valid cycle"}, 32'(first), 32'(exp_first));
      chk({tag, " rows delivered"}, 32'(next_row), 32'(exp_deliv));
      chk({tag, " rows_out"}, 32'(bus.rows_out), 32'(exp_total % 65536));
      chk({tag, " overflow end"}, 32'(bus.overflow), 32'(exp_ovf_end));
      chk({tag, " out_valid end"}, 32'(bus.out_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      psum_row_t exp_row;

      vecs[0] = '{16'hFFFF, 'h1000, 1'b0, 1'b1, 'h1000, 0};
      vecs[1] = '{16'h0000, 'h0000, 1'b0, 1'b1, 'h1000, 0};
      vecs[2] = '{16'hFFFF, 'h2000, 1'b1, 1'b1, 'h2000, 1};
      vecs[3] = '{16'h0000, 'h0000, 1'b1, 1'b0, 'h0000, 2};
      vecs[4] = '{16'h0001, 'h4000, 1'b1, 1'b0, 'h0000, 2};
      vecs[5] = '{16'hFFFE, 'h4000, 1'b1, 1'b1, 'h4000, 2};
      vecs[6] = '{16'h0000, 'h0000, 1'b0, 1'b1, 'h4000, 2};
      vecs[7] = '{16'hFFFF, 'h5000, 1'b1, 1'b1, 'h5000, 3};
      vecs[8] = '{16'h0000, 'h0000, 1'b1, 1'b0, 'h0000, 4};

      rst = 1'b0;
      drive_idle();
      do_reset("por");

      for (int i = 0; i < 9; i++) begin
         bus.sys_valid_out = vecs[i].vmask;
         for (int j = 0; j < SYS_N; j++) bus.sys_output[j] = psum_t'(vecs[i].base + j);
         bus.out_ready = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid)
            chk_row($sformatf("vec%0d out_data", i), bus.out_data, mkrow(vecs[i].exp_base, 0));
         chk($sformatf("vec%0d rows_out", i), 32'(bus.rows_out), 32'(vecs[i].exp_rows));
         chk($sformatf("vec%0d overflow", i), 32'(bus.overflow), 0);
      end
      drive_idle();

      do_reset("pre single");
      stream("single", 100, 1, 0, 24, 15, -1, 1, 1'b0);
      stream("backpressure", 0, 4, 25, 40, 15, -1, 4, 1'b0);
      stream("overflow", 0, 33, 60, 100, 15, 32, 32, 1'b1);

      do_reset("pre fullpop");
      stream("fullpop", 0, 40, 32, 80, 15, -1, 40, 1'b0);
      stream("partial", 0, 3, 0, 8, -1, -1, 0, 1'b0);
      do_reset("midstream");
      stream("fresh", 'h500, 1, 0, 24, 15, -1, 1, 1'b0);

      bus.out_ready        = 1'b1;
      bus.sys_valid_out    = 16'h0001;
      bus.sys_output[0]    = 32'hA0;
      @(negedge clk);
      chk("uneven push0 valid", 32'(bus.out_valid), 0);
      bus.sys_output[0]    = 32'hA1;
      @(negedge clk);
      chk("uneven push1 valid", 32'(bus.out_valid), 0);
      bus.sys_valid_out    = 16'hFFFE;
      for (int j = 1; j < SYS_N; j++) bus.sys_output[j] = psum_t'('hB0 + j);
      bus.sys_output[0]    = '0;
      @(negedge clk);
      chk("uneven complete valid", 32'(bus.out_valid), 1);
      exp_row = mkrow('hB0, 0);
      exp_row[0] = 32'hA0;
      chk_row("uneven complete data", bus.out_data, exp_row);
      bus.sys_valid_out    = '0;
      @(negedge clk);
      exp_total++;
      chk("uneven after pop valid", 32'(bus.out_valid), 0);
      chk("uneven rows_out", 32'(bus.rows_out), 32'(exp_total));
      bus.sys_valid_out    = 16'hFFFE;
      for (int j = 1; j < SYS_N; j++) bus.sys_output[j] = psum_t'('hC0 + j);
      @(negedge clk);
      exp_row = mkrow('hC0, 0);
      exp_row[0] = 32'hA1;
      chk("uneven leftover valid", 32'(bus.out_valid), 1);
      chk_row("uneven leftover data", bus.out_data, exp_row);
      bus.sys_valid_out    = '0;
      @(negedge clk);
      chk("uneven drained valid", 32'(bus.out_valid), 0);
      drive_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output collector and de-skew buffer on the bottom edge of the 16x16 systolic array. The array emits each result row as a diagonal wavefront: column j's 32-bit psum arrives j cycles after column 0's, qualified by its own valid. This block buffers each column independently, realigns the words into complete rows, and presents one row per beat on a valid/ready stream to the accumulator/writeback stage. The array cannot stall, so the block absorbs backpressure up to DEPTH rows and flags any loss.

## Interface
Parameters:
- N, 16, number of array columns.
- WIDTH, 32, psum word width.
- DEPTH, 32, rows buffered per column (power of two, at least 2).

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset; 0 = reset.
- sys_output  in  [WIDTH-1:0] x N  bottom-row psums from the array.
- sys_valid_out  in  1 x N  per-column valid for sys_output.
- out_data  out  [WIDTH-1:0] x N  aligned row; out_data[j] is the column j word.
- out_valid  out  1  a complete row is available.
- out_ready  in  1  downstream accepts the row.
- overflow  out  1  sticky; at least one word was dropped.
- rows_out  out  16  count of rows delivered; wraps mod 2^16.

## Operation
- Each column has its own FIFO (DEPTH x WIDTH) with read/write pointers and an occupancy count of width clog2(DEPTH)+1.
- Push: in any cycle with sys_valid_out[j]=1, column j writes sys_output[j]. Columns push independently; no inter-column timing is checked.
- A row is complete when every column FIFO is non-empty. In that case out_valid=1 and out_data[j] is the head of FIFO j.
- Pop: when out_valid && out_ready, all N FIFOs pop their heads together and rows_out increments.
- Push on a full FIFO:
  - If a pop occurs in the same cycle, the push is accepted and occupancy is unchanged.
  - Otherwise the word is dropped, the FIFO is unchanged, and overflow is set to 1.
- overflow stays 1 until reset. There is no other clear.
- Pointers wrap modulo DEPTH.
- Push and pop on the same non-full, non-empty FIFO in the same cycle leave occupancy unchanged.
- Push on an empty FIFO: the word is readable on the next cycle only. There is no write-to-read bypass.

## Timing
- Reset values, applied one cycle after rst=0 is sampled: all pointers and counts 0, out_valid=0, overflow=0, rows_out=0. out_data is don't-care while out_valid=0.
- Reset asserted mid-operation discards all buffered words.
- Latency: the last column's word written at cycle t produces out_valid=1 at t+1. For a fully skewed row, that is 16 cycles after column 0 pushed.
- out_valid and out_data are driven from registered state only: FIFO counts and heads. No combinational path runs from sys_* or out_ready to out_valid.
- out_data holds stable while out_valid=1 and out_ready=0.
- Back-to-back rows: with out_ready held at 1, one row is delivered per cycle.
- overflow rises the cycle after the dropping push.
- rows_out updates the cycle after the accepting handshake.

## Structure
- Shared package systolic_pkg holds:
  - the constants SYS_N=16 and PSUM_W=32;
  - typedef psum_t (logic [PSUM_W-1:0]);
  - typedef psum_row_t (psum_t [SYS_N-1:0]).
- Sub-module drain_col_fifo: one column FIFO, instantiated N times in a generate loop. Ports: clk, rst, push, din, pop, dout, empty, full, drop.
- The top level ANDs the N ~empty flags to form out_valid, ORs the N drop flags into the sticky overflow, and owns rows_out.

## Test plan
- Single skewed row: column j pushes 100+j at cycle j, out_ready=1 → out_valid=1 for exactly one cycle, at cycle 16, with out_data[j]=100+j; rows_out=1.
- Backpressure: stream 4 skewed rows (row r, column j value r*16+j), out_ready=0 until cycle 25, then 1 → 4 consecutive beats in order r=0..3, data exact; out_data stable while stalled.
- Overflow: DEPTH=32, out_ready=0, stream 33 rows → overflow=1 the cycle after the 33rd push on column 0. Releasing out_ready yields exactly rows 0..31 intact, then out_valid=0.
- Full plus simultaneous pop: fill 32 rows, then keep streaming with out_ready=1 → no drop, overflow stays 0, and every row arrives in order.
- Reset mid-stream: drive rst=0 while 3 rows are partially buffered → next cycle all counts 0, out_valid=0, rows_out=0. A fresh row afterwards drains correctly.
- Uneven columns: push 2 words on column 0 only → out_valid stays 0. Completing columns 1..15 once → exactly one row out; column 0 keeps 1 word.
